// File: rtl/hilo_muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ops_pkg
//  Description : ALU control codes shared with the ALU control decoder, and
//                the state encoding of the HI/LO multiply/divide sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_ops_pkg;

  // 5-bit ALU control codes handled by the HI/LO unit
  localparam logic [4:0] OP_MULT = 5'b00101;
  localparam logic [4:0] OP_DIV  = 5'b01011;
  localparam logic [4:0] OP_MADD = 5'b01100;
  localparam logic [4:0] OP_MSUB = 5'b01101;
  localparam logic [4:0] OP_MFHI = 5'b10000;
  localparam logic [4:0] OP_MTHI = 5'b10001;
  localparam logic [4:0] OP_MFLO = 5'b10010;
  localparam logic [4:0] OP_MTLO = 5'b10011;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } muldiv_state_e;

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_muldiv_unit_if
//  Description : EX-stage request/response bundle between the pipeline
//                (master) and the HI/LO multiply/divide unit (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  result, busy, stall, done, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output result, busy, stall, done, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/hilo_muldiv_unit_iter_core.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_iter_core
//  Description : Unsigned iteration datapath. One step per cycle of either
//                shift-add multiply or restoring divide on operand magnitudes.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               load,
  input  wire logic               step,
  input  wire logic               div,
  input  wire logic [WIDTH-1:0]   mag_a,
  input  wire logic [WIDTH-1:0]   mag_b,
  output logic      [2*WIDTH-1:0] product,
  output logic      [WIDTH-1:0]   quotient,
  output logic      [WIDTH-1:0]   remainder
);

  // Multiply: r_acc = {partial product, remaining multiplier bits}.
  // Divide:   r_acc upper half is the partial remainder, r_quo shifts the
  //           dividend out at the top and quotient bits in at the bottom.
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_b;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;

  // Next-step arithmetic for both algorithms
  always_comb begin
    w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_rem_sh = {r_acc[2*WIDTH-1:WIDTH], r_quo[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, r_b};
  end

  // Load magnitudes, then advance one iteration per step
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_quo <= '0;
      r_b   <= '0;
    end else if (load) begin
      r_acc <= {{WIDTH{1'b0}}, mag_a};
      r_quo <= mag_a;
      r_b   <= mag_b;
    end else if (step) begin
      if (div) begin
        // Restore (keep the shifted remainder) when the trial went negative
        r_acc[2*WIDTH-1:WIDTH] <= w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
        r_quo                  <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
      end else begin
        r_acc <= {w_sum, r_acc[WIDTH-1:1]};
      end
    end
  end

  assign product   = r_acc;
  assign quotient  = r_quo;
  assign remainder = r_acc[2*WIDTH-1:WIDTH];

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_muldiv_unit
//  Description : HI/LO register owner and multi-cycle mult/div/madd/msub
//                sequencer with pipeline stall handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_muldiv_unit
  import alu_ops_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  wire logic          clk,
  input  wire logic          rst,
  hilo_muldiv_unit_if.slave  bus
);

  localparam int          CW      = $clog2(ITER + 1);
  localparam logic [1:0]  ST_IDLE = 2'(S_IDLE);
  localparam logic [1:0]  ST_MUL  = 2'(S_MUL);
  localparam logic [1:0]  ST_DIV  = 2'(S_DIV);
  localparam logic [1:0]  ST_FIX  = 2'(S_FIX);

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic [4:0]         r_op;
  logic               r_neg;
  logic               r_sign_a;
  logic               r_b_zero;
  logic [WIDTH-1:0]   r_a;

  logic               w_busy;
  logic               w_is_mul_op;
  logic               w_is_div_op;
  logic               w_load;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH-1:0]   w_quotient;
  logic [WIDTH-1:0]   w_remainder;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_hilo;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  // Request decode and operand magnitudes
  always_comb begin
    w_busy      = (r_state != ST_IDLE);
    w_is_mul_op = (bus.op == OP_MULT) || (bus.op == OP_MADD) || (bus.op == OP_MSUB);
    w_is_div_op = (bus.op == OP_DIV);
    w_load      = (r_state == ST_IDLE) && bus.start && (w_is_mul_op || w_is_div_op);
    w_mag_a     = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
    w_mag_b     = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;
  end

  muldiv_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (w_load),
    .step      ((r_state == ST_MUL) || (r_state == ST_DIV)),
    .div       (r_state == ST_DIV),
    .mag_a     (w_mag_a),
    .mag_b     (w_mag_b),
    .product   (w_product),
    .quotient  (w_quotient),
    .remainder (w_remainder)
  );

  // Sign correction and accumulate, consumed in the FIX cycle
  always_comb begin
    w_prod_s = r_neg ? (~w_product + 1'b1) : w_product;
    w_hilo   = {r_hi, r_lo};
    w_fix_hi = '0;
    w_fix_lo = '0;
    if (r_op == OP_DIV) begin
      if (r_b_zero) begin
        // Divide by zero: no fixup, dividend lands in HI
        w_fix_hi = r_a;
        w_fix_lo = '1;
      end else begin
        w_fix_lo = r_neg    ? (~w_quotient  + 1'b1) : w_quotient;
        w_fix_hi = r_sign_a ? (~w_remainder + 1'b1) : w_remainder;
      end
    end else begin
      case (r_op)
        OP_MADD: w_hilo = w_hilo + w_prod_s;
        OP_MSUB: w_hilo = w_hilo - w_prod_s;
        default: w_hilo = w_prod_s;
      endcase
      {w_fix_hi, w_fix_lo} = w_hilo;
    end
  end

  // Sequencer FSM, HI/LO ownership and completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_sign_a <= 1'b0;
      r_b_zero <= 1'b0;
      r_a      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_state  <= w_is_div_op ? ST_DIV : ST_MUL;
            r_cnt    <= CW'(ITER - 1);
            r_op     <= bus.op;
            r_neg    <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            r_sign_a <= bus.a[WIDTH-1];
            r_b_zero <= (bus.b == '0);
            r_a      <= bus.a;
          end else if (bus.start && (bus.op == OP_MTHI)) begin
            r_hi <= bus.a;
          end else if (bus.start && (bus.op == OP_MTLO)) begin
            r_lo <= bus.a;
          end
        end
        ST_MUL, ST_DIV: begin
          if (r_cnt == '0) begin
            r_state <= ST_FIX;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_FIX: begin
          r_state <= ST_IDLE;
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_done  <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Handshake and move-from result, all combinational
  always_comb begin
    bus.busy   = w_busy;
    bus.stall  = bus.start && w_busy;
    bus.done   = r_done;
    bus.hi     = r_hi;
    bus.lo     = r_lo;
    bus.result = '0;
    if (bus.start && (bus.op == OP_MFHI)) begin
      bus.result = r_hi;
    end else if (bus.start && (bus.op == OP_MFLO)) begin
      bus.result = r_lo;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_muldiv_unit
//  Description : Directed self-checking bench for hilo_muldiv_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_muldiv_unit;
  import alu_ops_pkg::*;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  hilo_muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

  hilo_muldiv_unit #(
    .WIDTH (WIDTH),
    .ITER  (WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one cycle
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Wait for Done, counting Busy cycles on the way
  task automatic wait_done(input string tag, output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done) break;
      if (bus.busy) busy_cycles++;
      tick();
    end
    if (!bus.done) check({tag, "_timeout"}, 64'(bus.done), 64'd1);
  endtask

  // Full iterative op: latency, results, single-cycle Done
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int nb;
    issue(op, a, b);
    wait_done(tag, nb);
    check({tag, "_busy_cycles"}, 64'(nb), 64'd33);
    check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    tick();
    check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int nb;
    int n_stall;
    bus.start = 1'b0;
    bus.op    = 5'd0;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);

    // 7 * -3 = -21
    run_op("mult", OP_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    // Moves, immediate read-back and zero-latency reads
    issue(OP_MTHI, 32'h1234_5678, 32'd0);
    bus.start = 1'b1;
    bus.op    = OP_MFHI;
    #1;
    check("mfhi_after_mthi", 64'(bus.result), 64'h1234_5678);
    check("mfhi_no_stall", 64'(bus.stall), 64'd0);
    bus.op = OP_MTHI;
    bus.a  = 32'd0;
    tick();
    bus.op = OP_MTLO;
    bus.a  = 32'd10;
    tick();
    bus.start = 1'b0;
    check("mtlo_lo", 64'(bus.lo), 64'd10);
    check("mt_no_busy", 64'(bus.busy), 64'd0);
    check("result_idle_zero", 64'(bus.result), 64'd0);

    // {0,10} + 30 = 40
    run_op("madd", OP_MADD, 32'd5, 32'd6, 32'd0, 32'd40);
    bus.start = 1'b1;
    bus.op    = OP_MFHI;
    #1;
    check("mfhi_madd", 64'(bus.result), 64'd0);
    bus.op = OP_MFLO;
    #1;
    check("mflo_madd", 64'(bus.result), 64'd40);
    tick();
    bus.start = 1'b0;
    check("mf_no_busy", 64'(bus.busy), 64'd0);

    // 40 - (3 * -4) = 52, then 52 - 100 = -48
    run_op("msub1", OP_MSUB, 32'd3, 32'hFFFF_FFFC, 32'd0, 32'd52);
    run_op("msub2", OP_MSUB, 32'd10, 32'd10, 32'hFFFF_FFFF, 32'hFFFF_FFD0);

    // Signed divide cases
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_op("div_by0", OP_DIV, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF);
    run_op("div_minneg", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    // mflo held during Busy stalls every cycle; retry returns the new LO
    issue(OP_MULT, 32'd3, 32'd4);
    bus.start = 1'b1;
    bus.op    = OP_MFLO;
    n_stall   = 0;
    for (int i = 0; i < 100; i++) begin
      if (!bus.busy) break;
      if (bus.stall) n_stall++;
      tick();
    end
    check("stall_cycles", 64'(n_stall), 64'd33);
    check("stall_clear", 64'(bus.stall), 64'd0);
    check("mflo_retry", 64'(bus.result), 64'd12);
    tick();
    bus.start = 1'b0;

    // mthi during Busy is ignored
    issue(OP_MULT, 32'hFFFF_FFFF, 32'd1);
    bus.start = 1'b1;
    bus.op    = OP_MTHI;
    bus.a     = 32'h0000_DEAD;
    for (int i = 0; i < 5; i++) tick();
    bus.start = 1'b0;
    wait_done("mthi_busy", nb);
    check("mthi_busy_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    check("mthi_busy_lo", 64'(bus.lo), 64'hFFFF_FFFF);
    tick();

    // Reset during MUL aborts the operation
    issue(OP_MULT, 32'd7, 32'hFFFF_FFFD);
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_hi", 64'(bus.hi), 64'd0);
    check("abort_lo", 64'(bus.lo), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    tick();
    check("abort_done_late", 64'(bus.done), 64'd0);
    run_op("div_100_7", OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
